immediate_generation_pipe: RTL and testbench

Parametrised, buffered immediate generator for the ID stage. Accepts a raw instruction word, a format select and a pipeline tag through a valid/ready handshake. Produces the sign- or zero-extended XLEN-wide immediate from an internal FIFO with registered outputs. It sits between the instruction-fetch/decode handshake and the ID/EX register, so decode can keep accepting instructions while EX stalls.

---
 rtl/immediate_generation_pipe_if.sv | 49 ++++
 rtl/immediate_generation_pipe.sv | 134 +++++++++++++
 tb/tb_immediate_generation_pipe.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/immediate_generation_pipe_if.sv
// Handshake bundle for immediate_generation_pipe: producer-side push channel and
// consumer-side pop channel with the head entry's immediate, tag, error flag and occupancy.
interface immediate_generation_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             IN_VALID;
    logic             IN_READY;
    logic [31:0]      INSTRUCTION;
    logic [2:0]       SELECT;
    logic [TAG_W-1:0] TAG_IN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [XLEN-1:0]  OUT;
    logic [TAG_W-1:0] TAG_OUT;
    logic             ERR;
    logic [CNT_W-1:0] COUNT;

    modport master (
        output IN_VALID,
        output INSTRUCTION,
        output SELECT,
        output TAG_IN,
        output OUT_READY,
        input  IN_READY,
        input  OUT_VALID,
        input  OUT,
        input  TAG_OUT,
        input  ERR,
        input  COUNT
    );

    modport slave (
        input  IN_VALID,
        input  INSTRUCTION,
        input  SELECT,
        input  TAG_IN,
        input  OUT_READY,
        output IN_READY,
        output OUT_VALID,
        output OUT,
        output TAG_OUT,
        output ERR,
        output COUNT
    );
endinterface

// File: rtl/immediate_generation_pipe.sv
// Buffered ID-stage immediate generator: decodes the immediate at push time and queues it in a
// circular FIFO. Define IMMGEN_ZIMM_EN to support the CSR zimm format (SELECT 110).
module immediate_generation_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
) (
    input logic                       CLK,
    input logic                       RESET,
    input logic                       FLUSH,
    immediate_generation_pipe_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        SelU     = 3'b000,
        SelJ     = 3'b001,
        SelI     = 3'b010,
        SelB     = 3'b011,
        SelS     = 3'b100,
        SelShamt = 3'b101,
        SelZimm  = 3'b110,
        SelRsvd  = 3'b111
    } sel_e;

    logic [31:0]      instr;
    sel_e             sel;
    logic [XLEN-1:0]  imm;
    logic             imm_err;

    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic             err_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic head_valid;

    logic unused_opcode;

    assign instr         = bus.INSTRUCTION;
    assign sel           = sel_e'(bus.SELECT);
    assign unused_opcode = ^instr[6:0];

    // Each format is assembled narrow and then widened through a signed cast so the same
    // expression sign-extends correctly for both XLEN=32 and XLEN=64.
    always_comb begin
        imm     = '0;
        imm_err = 1'b0;
        case (sel)
            SelU: imm = XLEN'($signed({instr[31:12], 12'b0}));
            SelJ: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            SelI: imm = XLEN'($signed(instr[31:20]));
            SelB: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            SelS: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            SelShamt: begin
                if (XLEN == 64) begin
                    imm = XLEN'(instr[25:20]);
                end else begin
                    imm = XLEN'(instr[24:20]);
                end
            end
`ifdef IMMGEN_ZIMM_EN
            SelZimm: imm = XLEN'(instr[19:15]);
`else
            SelZimm: imm_err = 1'b1;
`endif
            SelRsvd: imm_err = 1'b1;
            default: imm_err = 1'b1;
        endcase
    end

    // Ready depends only on occupancy, so a full FIFO cannot accept even when popping.
    assign bus.IN_READY = (count_q < CNT_W'(DEPTH));
    assign head_valid   = (count_q != '0);
    assign push         = bus.IN_VALID && bus.IN_READY;
    assign pop          = head_valid && bus.OUT_READY;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge CLK) begin
        if (push && RESET && !FLUSH) begin
            imm_mem[wr_ptr_q] <= imm;
            tag_mem[wr_ptr_q] <= bus.TAG_IN;
            err_mem[wr_ptr_q] <= imm_err;
        end
    end

    assign bus.OUT_VALID = head_valid;
    assign bus.OUT       = head_valid ? imm_mem[rd_ptr_q] : '0;
    assign bus.TAG_OUT   = head_valid ? tag_mem[rd_ptr_q] : '0;
    assign bus.ERR       = head_valid ? err_mem[rd_ptr_q] : 1'b0;
    assign bus.COUNT     = count_q;

endmodule

// File: tb/tb_immediate_generation_pipe.sv
// Directed plus randomized bench for immediate_generation_pipe at XLEN=32 (scoreboarded)
// and XLEN=64 (directed).
module tb_immediate_generation_pipe;
    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;
    bit   sb_on;

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t sb[$];

    immediate_generation_pipe_if #(.XLEN(32), .DEPTH(2), .TAG_W(5)) b32 ();
    immediate_generation_pipe_if #(.XLEN(64), .DEPTH(2), .TAG_W(5)) b64 ();

    immediate_generation_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) dut32 (
        .CLK  (clk),
        .RESET(rst_n),
        .FLUSH(flush),
        .bus  (b32)
    );

    immediate_generation_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(5)) dut64 (
        .CLK  (clk),
        .RESET(rst_n),
        .FLUSH(flush),
        .bus  (b64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode built from the ISA bit layouts as 64-bit values.
    function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [2:0] s,
                                              input int xlen, output logic e);
        logic [63:0] v;
        v = '0;
        e = 1'b0;
        case (s)
            3'd0: v = {{32{i[31]}}, i[31:12], 12'h000};
            3'd1: v = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            3'd2: v = {{52{i[31]}}, i[31:20]};
            3'd3: v = {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            3'd4: v = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd5: v = (xlen == 64) ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
`ifdef IMMGEN_ZIMM_EN
            3'd6: v = {59'd0, i[19:15]};
`else
            3'd6: e = 1'b1;
`endif
            default: e = 1'b1;
        endcase
        if (xlen == 32) v = {32'd0, v[31:0]};
        return v;
    endfunction

    // Scoreboard: the sample point sits mid-cycle, so these are the values the next edge acts on.
    always @(negedge clk) begin
        if (sb_on) begin
            chk("count_vs_sb", 64'(b32.COUNT), 64'(sb.size()));
            if (!rst_n || flush) begin
                sb.delete();
            end else begin
                if (b32.OUT_VALID && b32.OUT_READY) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 64'(1), 64'(0));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_imm", 64'(b32.OUT), 64'(e.imm));
                        chk("sb_tag", 64'(b32.TAG_OUT), 64'(e.tag));
                        chk("sb_err", 64'(b32.ERR), 64'(e.err));
                    end
                end
                if (b32.IN_VALID && b32.IN_READY) begin
                    exp_t n;
                    logic [63:0] v;
                    logic        er;
                    v     = model_imm(b32.INSTRUCTION, b32.SELECT, 32, er);
                    n.imm = v[31:0];
                    n.tag = b32.TAG_IN;
                    n.err = er;
                    sb.push_back(n);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s,
                         input logic [4:0] t);
        b32.IN_VALID    = v;
        b32.INSTRUCTION = i;
        b32.SELECT      = s;
        b32.TAG_IN      = t;
    endtask

    task automatic drive64(input logic v, input logic [31:0] i, input logic [2:0] s);
        b64.IN_VALID    = v;
        b64.INSTRUCTION = i;
        b64.SELECT      = s;
        b64.TAG_IN      = 5'd9;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sb_on = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        drive64(1'b0, 32'h0, 3'd0);
        b32.OUT_READY = 1'b0;
        b64.OUT_READY = 1'b0;
        step();
        step();

        chk("rst_count", 64'(b32.COUNT), 64'(0));
        chk("rst_out_valid", 64'(b32.OUT_VALID), 64'(0));
        chk("rst_in_ready", 64'(b32.IN_READY), 64'(1));
        chk("rst_out", 64'(b32.OUT), 64'(0));
        chk("rst_tag_err", 64'({b32.TAG_OUT, b32.ERR}), 64'(0));
        chk("rst_count64", 64'(b64.COUNT), 64'(0));
        rst_n = 1'b1;
        sb_on = 1'b1;

        // Basic I-type, single-cycle latency, then hold under backpressure.
        drive(1'b1, 32'hFFF00093, 3'b010, 5'd3);
        step();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        chk("i_out", 64'(b32.OUT), 64'hFFFFFFFF);
        chk("i_tag", 64'(b32.TAG_OUT), 64'(3));
        chk("i_err", 64'(b32.ERR), 64'(0));
        chk("i_count", 64'(b32.COUNT), 64'(1));
        chk("i_out_valid", 64'(b32.OUT_VALID), 64'(1));
        step();
        chk("i_hold", 64'(b32.OUT), 64'hFFFFFFFF);
        b32.OUT_READY = 1'b1;
        step();
        chk("i_drained", 64'(b32.COUNT), 64'(0));
        chk("i_out_zero", 64'(b32.OUT), 64'(0));

        // B then U back to back with the consumer ready: simultaneous push/pop keeps COUNT.
        drive(1'b1, 32'hFE000EE3, 3'b011, 5'd4);
        step();
        chk("b_out", 64'(b32.OUT), 64'hFFFFFFFC);
        drive(1'b1, 32'h123450B7, 3'b000, 5'd5);
        step();
        chk("u_out", 64'(b32.OUT), 64'h12345000);
        chk("bu_count", 64'(b32.COUNT), 64'(1));
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        step();
        chk("bu_drained", 64'(b32.COUNT), 64'(0));

        // Full: third push refused, and a pop at full does not admit a push.
        b32.OUT_READY = 1'b0;
        drive(1'b1, 32'h00100093, 3'b010, 5'd1);
        step();
        chk("full_ready1", 64'(b32.IN_READY), 64'(1));
        drive(1'b1, 32'h00200093, 3'b010, 5'd2);
        step();
        chk("full_count2", 64'(b32.COUNT), 64'(2));
        chk("full_ready0", 64'(b32.IN_READY), 64'(0));
        drive(1'b1, 32'h00300093, 3'b010, 5'd3);
        step();
        chk("full_count_hold", 64'(b32.COUNT), 64'(2));
        chk("full_head", 64'(b32.OUT), 64'(1));
        b32.OUT_READY = 1'b1;
        step();
        chk("full_pop_no_push", 64'(b32.COUNT), 64'(1));
        chk("full_second", 64'(b32.OUT), 64'(2));
        chk("full_second_tag", 64'(b32.TAG_OUT), 64'(2));
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        step();
        chk("full_drained", 64'(b32.COUNT), 64'(0));

        // Flush discards contents and a same-cycle push; reset wins over flush.
        b32.OUT_READY = 1'b0;
        drive(1'b1, 32'h00500093, 3'b010, 5'd1);
        step();
        step();
        chk("fl_count2", 64'(b32.COUNT), 64'(2));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_count", 64'(b32.COUNT), 64'(0));
        chk("fl_out_valid", 64'(b32.OUT_VALID), 64'(0));
        chk("fl_out", 64'(b32.OUT), 64'(0));
        chk("fl_in_ready", 64'(b32.IN_READY), 64'(1));
        step();
        step();
        chk("rf_count2", 64'(b32.COUNT), 64'(2));
        rst_n = 1'b0;
        flush = 1'b1;
        step();
        rst_n = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        chk("rf_count", 64'(b32.COUNT), 64'(0));
        chk("rf_out_valid", 64'(b32.OUT_VALID), 64'(0));
        chk("rf_out", 64'(b32.OUT), 64'(0));

        // ZIMM depends on the build option; reserved select always errors.
        drive(1'b1, 32'h0007D073, 3'b110, 5'd6);
        step();
`ifdef IMMGEN_ZIMM_EN
        chk("zimm_out", 64'(b32.OUT), 64'h0F);
        chk("zimm_err", 64'(b32.ERR), 64'(0));
`else
        chk("zimm_out", 64'(b32.OUT), 64'(0));
        chk("zimm_err", 64'(b32.ERR), 64'(1));
`endif
        b32.OUT_READY = 1'b1;
        drive(1'b1, 32'h0007D073, 3'b111, 5'd7);
        step();
        chk("rsvd_out", 64'(b32.OUT), 64'(0));
        chk("rsvd_err", 64'(b32.ERR), 64'(1));
        chk("rsvd_tag", 64'(b32.TAG_OUT), 64'(7));
        drive(1'b1, 32'h03F01013, 3'b101, 5'd8);
        step();
        chk("shamt32", 64'(b32.OUT), 64'h1F);
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        step();

        // XLEN=64 instance.
        drive64(1'b1, 32'h800000B7, 3'b000);
        step();
        chk("x64_u", 64'(b64.OUT), 64'hFFFFFFFF80000000);
        chk("x64_count", 64'(b64.COUNT), 64'(1));
        b64.OUT_READY = 1'b1;
        drive64(1'b1, 32'h03F01013, 3'b101);
        step();
        chk("x64_shamt", 64'(b64.OUT), 64'h3F);
        chk("x64_count_pp", 64'(b64.COUNT), 64'(1));
        drive64(1'b0, 32'h0, 3'd0);
        step();
        chk("x64_drained", 64'(b64.COUNT), 64'(0));

        // Randomized traffic exercises pointer wrap and rare flushes against the scoreboard.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)));
            b32.OUT_READY = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        b32.OUT_READY = 1'b1;
        for (int n = 0; n < 8 && b32.COUNT != 0; n++) begin
            step();
        end
        step();
        chk("final_count", 64'(b32.COUNT), 64'(0));
        chk("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
